// File: rtl/mem_test_reporter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_test_reporter_pkg
// Purpose : Report codes, FSM states, ASCII constants and line-shape helpers.
// Revision: 1.0
// ============================================================================
package mem_test_reporter_pkg;

    typedef enum logic [1:0] {
        RPT_PASS     = 2'd0,
        RPT_FAIL     = 2'd1,
        RPT_PROGRESS = 2'd2,
        RPT_RESERVED = 2'd3
    } rpt_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_BUSY = 2'd2
    } state_e;

    localparam logic [7:0] c_ascii_cr    = 8'h0D;
    localparam logic [7:0] c_ascii_lf    = 8'h0A;
    localparam logic [7:0] c_ascii_sp    = 8'h20;
    localparam logic [7:0] c_ascii_p     = 8'h50;
    localparam logic [7:0] c_ascii_f     = 8'h46;
    localparam logic [7:0] c_ascii_r     = 8'h52;
    localparam logic [7:0] c_ascii_q     = 8'h3F;
    localparam logic [7:0] c_ascii_0     = 8'h30;
    localparam logic [7:0] c_ascii_a     = 8'h41;

    localparam int c_len_data_crlf  = 28;
    localparam int c_len_data_lf    = 27;
    localparam int c_len_short_crlf = 10;
    localparam int c_len_short_lf   = 9;

    function automatic logic is_data_line(input rpt_code_e code);
        return (code == RPT_PASS) || (code == RPT_FAIL);
    endfunction

    function automatic logic [4:0] line_last_idx(input rpt_code_e code, input logic crlf);
        if (is_data_line(code)) begin
            return crlf ? 5'(c_len_data_crlf - 1) : 5'(c_len_data_lf - 1);
        end
        return crlf ? 5'(c_len_short_crlf - 1) : 5'(c_len_short_lf - 1);
    endfunction

    function automatic logic [7:0] code_letter(input rpt_code_e code);
        case (code)
            RPT_PASS:     return c_ascii_p;
            RPT_FAIL:     return c_ascii_f;
            RPT_PROGRESS: return c_ascii_r;
            default:      return c_ascii_q;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_test_reporter_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_test_reporter_if
// Purpose : Result-event handshake from the sequencer plus the UART tx port.
// Revision: 1.0
// ============================================================================
interface mem_test_reporter_if #(
    parameter int ADDR_W = 23
);
    logic              report_valid;
    logic              report_ready;
    logic [1:0]        report_code;
    logic [ADDR_W-1:0] report_addr;
    logic [31:0]       report_expected;
    logic [31:0]       report_actual;
    logic [7:0]        tx_byte;
    logic              tx_en;
    logic              tx_ready;

    modport master (
        output report_valid, report_code, report_addr, report_expected, report_actual,
        input  report_ready,
        input  tx_byte, tx_en,
        output tx_ready
    );

    modport slave (
        input  report_valid, report_code, report_addr, report_expected, report_actual,
        output report_ready,
        output tx_byte, tx_en,
        input  tx_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_test_reporter_nibble_to_ascii.sv
`default_nettype none
// ============================================================================
// Module  : nibble_to_ascii
// Purpose : One hex nibble to its uppercase ASCII digit.
// Revision: 1.0
// ============================================================================
module nibble_to_ascii
    import mem_test_reporter_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    always_comb begin
        if (nibble < 4'd10) begin
            ascii = c_ascii_0 + {4'h0, nibble};
        end else begin
            ascii = c_ascii_a + {4'h0, nibble} - 8'd10;
        end
    end
endmodule
`default_nettype wire

// File: rtl/mem_test_reporter.sv
`default_nettype none
// ============================================================================
// Module  : mem_test_reporter
// Purpose : Formats memory-test result events as ASCII lines for the UART.
// Revision: 1.0
// ============================================================================
module mem_test_reporter
    import mem_test_reporter_pkg::*;
#(
    parameter int ADDR_W   = 23,
    parameter bit EOL_CRLF = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_test_reporter_if.slave   rpt,
    output logic                 busy,
    output logic [7:0]           drop_count
);

    state_e      r_state;
    rpt_code_e   r_code;
    logic [23:0] r_addr;
    logic [31:0] r_expected;
    logic [31:0] r_actual;
    logic [4:0]  r_idx;
    logic        r_ready;
    logic        r_tx_en;
    logic [7:0]  r_tx_byte;
    logic [7:0]  r_drop;

    logic [23:0] w_addr_ext;
    logic [2:0]  w_nsel;
    logic [3:0]  w_nibble;
    logic [7:0]  w_hex;
    logic [7:0]  w_eol_first;
    logic [7:0]  w_byte;
    logic [4:0]  w_last_idx;

    always_comb begin
        w_addr_ext = '0;
        w_addr_ext[ADDR_W-1:0] = rpt.report_addr;
    end

    // Digit fields: addr at 2..7, expected at 9..16, actual at 18..25, MS nibble first.
    always_comb begin
        w_nsel   = 3'd0;
        w_nibble = 4'h0;
        if (r_idx >= 5'd2 && r_idx <= 5'd7) begin
            w_nsel   = 3'(5'd7 - r_idx);
            w_nibble = r_addr[{w_nsel, 2'b00} +: 4];
        end else if (r_idx >= 5'd9 && r_idx <= 5'd16) begin
            w_nsel   = 3'(5'd16 - r_idx);
            w_nibble = r_expected[{w_nsel, 2'b00} +: 4];
        end else if (r_idx >= 5'd18 && r_idx <= 5'd25) begin
            w_nsel   = 3'(5'd25 - r_idx);
            w_nibble = r_actual[{w_nsel, 2'b00} +: 4];
        end
    end

    nibble_to_ascii u_nibble_to_ascii (
        .nibble (w_nibble),
        .ascii  (w_hex)
    );

    always_comb begin
        w_eol_first = EOL_CRLF ? c_ascii_cr : c_ascii_lf;
        w_last_idx  = line_last_idx(r_code, EOL_CRLF);
        w_byte      = w_hex;
        if (is_data_line(r_code)) begin
            case (r_idx)
                5'd0:                w_byte = code_letter(r_code);
                5'd1, 5'd8, 5'd17:   w_byte = c_ascii_sp;
                5'd26:               w_byte = w_eol_first;
                5'd27:               w_byte = c_ascii_lf;
                default:             w_byte = w_hex;
            endcase
        end else begin
            case (r_idx)
                5'd0:    w_byte = code_letter(r_code);
                5'd1:    w_byte = c_ascii_sp;
                5'd8:    w_byte = w_eol_first;
                5'd9:    w_byte = c_ascii_lf;
                default: w_byte = w_hex;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_code     <= RPT_PASS;
            r_addr     <= '0;
            r_expected <= '0;
            r_actual   <= '0;
            r_idx      <= '0;
            r_ready    <= 1'b0;
            r_tx_en    <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_drop     <= 8'h00;
        end else begin
            r_tx_en <= 1'b0;
            if (rpt.report_valid && !r_ready && r_drop != 8'hFF) begin
                r_drop <= r_drop + 8'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (rpt.report_valid && r_ready) begin
                        r_code     <= rpt_code_e'(rpt.report_code);
                        r_addr     <= w_addr_ext;
                        r_expected <= rpt.report_expected;
                        r_actual   <= rpt.report_actual;
                        r_idx      <= '0;
                        r_ready    <= 1'b0;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (rpt.tx_ready) begin
                        r_tx_byte <= w_byte;
                        r_tx_en   <= 1'b1;
                        r_state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // The UART dropping tx_ready is the acknowledgement of the byte.
                    if (!rpt.tx_ready) begin
                        if (r_idx == w_last_idx) begin
                            r_ready <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx   <= r_idx + 5'd1;
                            r_state <= ST_SEND;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rpt.report_ready = r_ready;
    assign rpt.tx_byte      = r_tx_byte;
    assign rpt.tx_en        = r_tx_en;
    assign busy             = (r_state != ST_IDLE);
    assign drop_count       = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_mem_test_reporter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_test_reporter
// Purpose : Self-checking bench: CRLF and LF instances against a string model.
// Revision: 1.0
// ============================================================================
module tb_mem_test_reporter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_test_reporter_if #(.ADDR_W(23)) ifa ();
    mem_test_reporter_if #(.ADDR_W(23)) ifb ();

    logic       busy_a, busy_b;
    logic [7:0] drop_a, drop_b;

    mem_test_reporter #(.ADDR_W(23), .EOL_CRLF(1'b1)) dut_a (
        .clk(clk), .rst(rst), .rpt(ifa.slave), .busy(busy_a), .drop_count(drop_a));
    mem_test_reporter #(.ADDR_W(23), .EOL_CRLF(1'b0)) dut_b (
        .clk(clk), .rst(rst), .rpt(ifb.slave), .busy(busy_b), .drop_count(drop_b));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // UART models: tx_ready falls after each strobe and stays low for gap cycles.
    int gap_a = 1, gap_b = 1, cnt_a = 0, cnt_b = 0;
    always @(posedge clk) begin
        if (!rst) begin
            ifa.tx_ready <= 1'b1; cnt_a <= 0;
        end else if (ifa.tx_en) begin
            ifa.tx_ready <= 1'b0; cnt_a <= gap_a;
        end else if (cnt_a > 1) begin
            cnt_a <= cnt_a - 1;
        end else begin
            ifa.tx_ready <= 1'b1; cnt_a <= 0;
        end
    end
    always @(posedge clk) begin
        if (!rst) begin
            ifb.tx_ready <= 1'b1; cnt_b <= 0;
        end else if (ifb.tx_en) begin
            ifb.tx_ready <= 1'b0; cnt_b <= gap_b;
        end else if (cnt_b > 1) begin
            cnt_b <= cnt_b - 1;
        end else begin
            ifb.tx_ready <= 1'b1; cnt_b <= 0;
        end
    end

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         width_err = 0;
    int         stab_err  = 0;
    logic       prev_en_a = 1'b0;
    logic [7:0] last_a    = 8'h00;
    bit         have_a    = 1'b0;

    always @(negedge clk) begin
        if (ifa.tx_en === 1'b1) begin
            qa.push_back(ifa.tx_byte);
            if (prev_en_a) width_err++;
            last_a = ifa.tx_byte;
            have_a = 1'b1;
        end else if (rst && have_a && ifa.tx_byte !== last_a) begin
            stab_err++;
        end
        if (!rst) have_a = 1'b0;
        prev_en_a = (ifa.tx_en === 1'b1);
        if (ifb.tx_en === 1'b1) qb.push_back(ifb.tx_byte);
    end

    function automatic string model_line(input logic [1:0] code, input logic [22:0] addr,
                                         input logic [31:0] e, input logic [31:0] a, input bit crlf);
        string s;
        logic [23:0] a24;
        a24 = {1'b0, addr};
        case (code)
            2'd0:    s = $sformatf("P %h %h %h", a24, e, a);
            2'd1:    s = $sformatf("F %h %h %h", a24, e, a);
            2'd2:    s = $sformatf("R %h", a24);
            default: s = $sformatf("? %h", a24);
        endcase
        s = s.toupper();
        return crlf ? {s, "\015\012"} : {s, "\012"};
    endfunction

    task automatic check_line(input string name, input bit use_b, input string exp);
        int n;
        int bad;
        logic [7:0] got;
        bad = -1;
        n = use_b ? qb.size() : qa.size();
        check({name, " length"}, n, exp.len());
        for (int i = 0; i < n && i < exp.len(); i++) begin
            got = use_b ? qb[i] : qa[i];
            if (got !== exp[i] && bad < 0) bad = i;
        end
        check({name, " first bad byte index"}, bad, -1);
    endtask

    task automatic issue(input logic [1:0] c, input logic [22:0] a, input logic [31:0] e,
                         input logic [31:0] x, input bit use_b);
        logic la, lb;
        @(posedge clk); #1;
        ifa.report_code = c; ifa.report_addr = a; ifa.report_expected = e; ifa.report_actual = x;
        ifa.report_valid = 1'b1;
        if (use_b) begin
            ifb.report_code = c; ifb.report_addr = a; ifb.report_expected = e; ifb.report_actual = x;
            ifb.report_valid = 1'b1;
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            la = ifa.report_valid && ifa.report_ready;
            lb = ifb.report_valid && ifb.report_ready;
            @(posedge clk); #1;
            if (la) ifa.report_valid = 1'b0;
            if (lb) ifb.report_valid = 1'b0;
            if (!ifa.report_valid && !ifb.report_valid) break;
        end
        check("event accepted", {31'd0, ifa.report_valid | ifb.report_valid}, 0);
        ifa.report_valid = 1'b0;
        ifb.report_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input bit use_b, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy_a && ifa.report_ready && (!use_b || (!busy_b && ifb.report_ready))) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, " back to idle"}, {31'd0, ok}, 1);
    endtask

    typedef struct {
        logic [1:0]  code;
        logic [22:0] addr;
        logic [31:0] exp_data;
        logic [31:0] act_data;
        int          gap;
        string       line_crlf;
        string       line_lf;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [1:0]  rc;
        logic [22:0] ra;
        logic [31:0] re, rx;
        int          n_en, exp_drop;
        bit          ok;

        vecs[0] = '{2'd1, 23'h001234, 32'h00000005, 32'h00000004, 1,
                    "F 001234 00000005 00000004\015\012", "F 001234 00000005 00000004\012"};
        vecs[1] = '{2'd0, 23'h7FFFFF, 32'hDEADBEEF, 32'hDEADBEEF, 50,
                    "P 7FFFFF DEADBEEF DEADBEEF\015\012", "P 7FFFFF DEADBEEF DEADBEEF\012"};
        vecs[2] = '{2'd2, 23'h100000, 32'h11111111, 32'h22222222, 2,
                    "R 100000\015\012", "R 100000\012"};
        vecs[3] = '{2'd3, 23'h00ABCD, 32'h0, 32'h0, 1,
                    "? 00ABCD\015\012", "? 00ABCD\012"};
        vecs[4] = '{2'd1, 23'h000000, 32'hFFFFFFFF, 32'h00000000, 3,
                    "F 000000 FFFFFFFF 00000000\015\012", "F 000000 FFFFFFFF 00000000\012"};

        ifa.report_valid = 1'b0; ifa.report_code = '0; ifa.report_addr = '0;
        ifa.report_expected = '0; ifa.report_actual = '0;
        ifb.report_valid = 1'b0; ifb.report_code = '0; ifb.report_addr = '0;
        ifb.report_expected = '0; ifb.report_actual = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset tx_en", {31'd0, ifa.tx_en}, 0);
        check("reset tx_byte", {24'd0, ifa.tx_byte}, 0);
        check("reset report_ready", {31'd0, ifa.report_ready}, 0);
        check("reset busy", {31'd0, busy_a}, 0);
        check("reset drop_count", {24'd0, drop_a}, 0);
        rst = 1'b1;
        @(negedge clk);
        check("ready one edge after release", {31'd0, ifa.report_ready}, 1);

        // Acceptance to first strobe latency on the CRLF instance.
        qa.delete();
        issue(2'd1, 23'h001234, 32'h5, 32'h4, 1'b0);
        check("ready low after accept", {31'd0, ifa.report_ready}, 0);
        check("busy after accept", {31'd0, busy_a}, 1);
        @(negedge clk);
        check("no strobe in first send cycle", {31'd0, ifa.tx_en}, 0);
        @(negedge clk);
        check("first strobe", {31'd0, ifa.tx_en}, 1);
        check("first byte letter", {24'd0, ifa.tx_byte}, 32'h46);
        @(negedge clk);
        check("strobe one cycle", {31'd0, ifa.tx_en}, 0);
        wait_idle("latency line", 1'b0, 500);
        check_line("latency line", 1'b0, "F 001234 00000005 00000004\015\012");

        foreach (vecs[k]) begin
            gap_a = vecs[k].gap; gap_b = vecs[k].gap;
            qa.delete(); qb.delete();
            issue(vecs[k].code, vecs[k].addr, vecs[k].exp_data, vecs[k].act_data, 1'b1);
            wait_idle($sformatf("vec%0d", k), 1'b1, 3000);
            check_line($sformatf("vec%0d crlf", k), 1'b0, vecs[k].line_crlf);
            check_line($sformatf("vec%0d lf", k), 1'b1, vecs[k].line_lf);
        end

        for (int k = 0; k < 20; k++) begin
            rc = 2'($urandom_range(0, 3));
            ra = 23'($urandom);
            re = $urandom;
            rx = $urandom;
            gap_a = $urandom_range(1, 4);
            gap_b = $urandom_range(1, 4);
            qa.delete(); qb.delete();
            issue(rc, ra, re, rx, 1'b1);
            wait_idle($sformatf("rand%0d", k), 1'b1, 1000);
            check_line($sformatf("rand%0d crlf", k), 1'b0, model_line(rc, ra, re, rx, 1'b1));
            check_line($sformatf("rand%0d lf", k), 1'b1, model_line(rc, ra, re, rx, 1'b0));
        end

        // Drop saturation while a slow line is in flight.
        gap_a = 30;
        qa.delete();
        check("drop_count before burst", {24'd0, drop_a}, 0);
        issue(2'd1, 23'h0ABCDE, 32'h12345678, 32'h9ABCDEF0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            ifa.report_valid = 1'b1;
            ifa.report_code  = 2'($urandom);
            ifa.report_addr  = 23'($urandom);
            ifa.report_expected = $urandom;
            ifa.report_actual   = $urandom;
            @(posedge clk); #1;
            ifa.report_valid = 1'b0;
        end
        exp_drop = (300 > 255) ? 255 : 300;
        check("busy during burst", {31'd0, busy_a}, 1);
        wait_idle("drop line", 1'b0, 2000);
        check("drop_count saturated", {24'd0, drop_a}, exp_drop);
        check_line("drop line", 1'b0, model_line(2'd1, 23'h0ABCDE, 32'h12345678, 32'h9ABCDEF0, 1'b1));

        // Asynchronous reset while the fifth strobe is high.
        gap_a = 1;
        issue(2'd1, 23'h000042, 32'hCAFEF00D, 32'h0, 1'b0);
        n_en = 0; ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ifa.tx_en === 1'b1) n_en++;
            if (n_en == 5) begin ok = 1'b1; break; end
        end
        check("reached fifth byte", {31'd0, ok}, 1);
        #1 rst = 1'b0;
        #1;
        check("tx_en cleared by reset", {31'd0, ifa.tx_en}, 0);
        check("drop_count cleared by reset", {24'd0, drop_a}, 0);
        check("busy cleared by reset", {31'd0, busy_a}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        qa.delete();
        issue(2'd1, 23'h3456AB, 32'h0000BEEF, 32'h0000BEE0, 1'b0);
        wait_idle("after reset", 1'b0, 500);
        check("after reset first byte", {24'd0, qa[0]}, 32'h46);
        check_line("after reset", 1'b0, "F 3456AB 0000BEEF 0000BEE0\015\012");

        check("strobe width violations", width_err, 0);
        check("tx_byte stability violations", stab_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global timeout: got 1, expected 0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
